control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 198 +++++++++++++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit: Moore FSM decoding datapath strobes
// and mux selects from the current state.  Only the branch PC_Write is
// qualified combinationally by the eq flag.  While reset is held low every
// output is forced to 0.
// Optional feature macro: OVERFLOW_EXC_EN enables arithmetic-overflow and
// unknown-instruction exceptions (EXC0..EXC3, EPC_Write).
module control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    input  logic       eq,
    output logic       PC_Write,
    output logic       MEM_ReadWrite,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic       AB_Write,
    output logic       ALUOut_Write,
    output logic       EPC_Write,
    output logic       ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [1:0] IorD,
    output logic [1:0] Reg_Dst,
    output logic [2:0] Mem_To_Reg,
    output logic [2:0] PC_Src,
    output logic [2:0] ALU_Sel,
    output logic [4:0] state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH0 = 5'd1,
        S_FETCH1 = 5'd2,
        S_FETCH2 = 5'd3,
        S_DECODE = 5'd4,
        S_R_EXEC = 5'd5,
        S_R_WB   = 5'd6,
        S_JR     = 5'd7,
        S_I_EXEC = 5'd8,
        S_I_WB   = 5'd9,
        S_BR     = 5'd10,
        S_J      = 5'd11,
        S_LUI    = 5'd12,
        S_ADDR   = 5'd13,
        S_SW     = 5'd14,
        S_LW0    = 5'd15,
        S_LW1    = 5'd16,
        S_LW_WB  = 5'd17,
        S_EXC0   = 5'd18,
        S_EXC1   = 5'd19,
        S_EXC2   = 5'd20,
        S_EXC3   = 5'd21
    } state_t;

    state_t state, state_next;

    // The zero flag is not needed by any instruction in this subset.
    logic unused_zero;
    assign unused_zero = zero;

`ifdef OVERFLOW_EXC_EN
    localparam state_t UNKNOWN_NEXT = S_EXC0;
`else
    localparam state_t UNKNOWN_NEXT = S_FETCH0;
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    assign state_dbg = state;

    // State register; reset low drops straight into RESET regardless of clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_RESET;
        else        state <= state_next;
    end

    // Next-state sequencing: fetch/decode, per-class execute, back to FETCH0.
    always_comb begin
        state_next = S_FETCH0;
        case (state)
            S_RESET:  state_next = S_FETCH0;
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
                            state_next = S_R_EXEC;
                        else if (funct == FN_JR)
                            state_next = S_JR;
                        else
                            state_next = UNKNOWN_NEXT;
                    end
                    OP_ADDI:        state_next = S_I_EXEC;
                    OP_BEQ, OP_BNE: state_next = S_BR;
                    OP_J:           state_next = S_J;
                    OP_LUI:         state_next = S_LUI;
                    OP_LW, OP_SW:   state_next = S_ADDR;
                    default:        state_next = UNKNOWN_NEXT;
                endcase
            end
`ifdef OVERFLOW_EXC_EN
            // 'and' cannot overflow, so only add/sub trap.
            S_R_EXEC: state_next = (overflow && funct != FN_AND) ? S_EXC0 : S_R_WB;
            S_I_EXEC: state_next = overflow ? S_EXC0 : S_I_WB;
            S_EXC0:   state_next = S_EXC1;
            S_EXC1:   state_next = S_EXC2;
            S_EXC2:   state_next = S_EXC3;
`else
            S_R_EXEC: state_next = S_R_WB;
            S_I_EXEC: state_next = S_I_WB;
`endif
            S_ADDR:   state_next = (opcode == OP_SW) ? S_SW : S_LW0;
            S_LW0:    state_next = S_LW1;
            S_LW1:    state_next = S_LW_WB;
            default:  state_next = S_FETCH0;
        endcase
    end

    // Output decode from the current state; everything is 0 while reset is low.
    always_comb begin
        PC_Write      = 1'b0;
        MEM_ReadWrite = 1'b0;
        IR_Write      = 1'b0;
        Reg_Write     = 1'b0;
        AB_Write      = 1'b0;
        ALUOut_Write  = 1'b0;
        EPC_Write     = 1'b0;
        ALUSrc_A      = 1'b0;
        ALUSrc_B      = 2'd0;
        IorD          = 2'd0;
        Reg_Dst       = 2'd0;
        Mem_To_Reg    = 3'd0;
        PC_Src        = 3'd0;
        ALU_Sel       = 3'b000;
        if (reset) begin
            case (state)
                S_RESET: begin
                    Reg_Write = 1'b1; Reg_Dst = 2'd2; Mem_To_Reg = 3'd7;
                end
                S_FETCH2: begin
                    IR_Write = 1'b1; ALUSrc_B = 2'd1; ALU_Sel = 3'b001; PC_Write = 1'b1;
                end
                S_DECODE: begin
                    AB_Write = 1'b1; ALUSrc_B = 2'd3; ALU_Sel = 3'b001; ALUOut_Write = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrc_A = 1'b1; ALUOut_Write = 1'b1;
                    case (funct)
                        FN_SUB:  ALU_Sel = 3'b010;
                        FN_AND:  ALU_Sel = 3'b011;
                        default: ALU_Sel = 3'b001;
                    endcase
                end
                S_R_WB:  begin Reg_Dst = 2'd1; Reg_Write = 1'b1; end
                S_JR:    begin ALUSrc_A = 1'b1; PC_Write = 1'b1; end
                S_I_EXEC, S_ADDR: begin
                    ALUSrc_A = 1'b1; ALUSrc_B = 2'd2; ALU_Sel = 3'b001; ALUOut_Write = 1'b1;
                end
                S_I_WB:  Reg_Write = 1'b1;
                S_BR: begin
                    ALUSrc_A = 1'b1; ALU_Sel = 3'b111; PC_Src = 3'd1;
                    PC_Write = (opcode == OP_BEQ) ? eq : !eq;
                end
                S_J:     begin PC_Src = 3'd2; PC_Write = 1'b1; end
                S_LUI:   begin Mem_To_Reg = 3'd6; Reg_Write = 1'b1; end
                S_SW:    begin IorD = 2'd1; MEM_ReadWrite = 1'b1; end
                S_LW0, S_LW1: IorD = 2'd1;
                S_LW_WB: begin Mem_To_Reg = 3'd1; Reg_Write = 1'b1; end
`ifdef OVERFLOW_EXC_EN
                S_EXC0: begin
                    ALUSrc_B = 2'd1; ALU_Sel = 3'b010; EPC_Write = 1'b1;
                end
                S_EXC1, S_EXC2: IorD = 2'd2;
                S_EXC3: begin PC_Src = 3'd4; PC_Write = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level reference model
// expands each instruction into its expected per-cycle control vectors,
// compared every cycle against the DUT outputs.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       overflow = 1'b0;
    logic       zero = 1'b0;
    logic       eq = 1'b0;
    logic       PC_Write, MEM_ReadWrite, IR_Write, Reg_Write, AB_Write;
    logic       ALUOut_Write, EPC_Write, ALUSrc_A;
    logic [1:0] ALUSrc_B, IorD, Reg_Dst;
    logic [2:0] Mem_To_Reg, PC_Src, ALU_Sel;
    logic [4:0] state_dbg;

    int checks = 0;
    int failures = 0;

`ifdef OVERFLOW_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [4:0] ST_RESET  = 5'd0;
    localparam logic [4:0] ST_FETCH0 = 5'd1;

    typedef struct packed {
        logic       pcw, mrw, irw, rw, abw, aow, epcw, srca;
        logic [1:0] srcb, iord, rdst;
        logic [2:0] m2r, pcsrc, alu;
    } vec_t;

    vec_t exp_q[$];

    control_unit dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero), .eq(eq),
        .PC_Write(PC_Write), .MEM_ReadWrite(MEM_ReadWrite), .IR_Write(IR_Write),
        .Reg_Write(Reg_Write), .AB_Write(AB_Write), .ALUOut_Write(ALUOut_Write),
        .EPC_Write(EPC_Write), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
        .IorD(IorD), .Reg_Dst(Reg_Dst), .Mem_To_Reg(Mem_To_Reg),
        .PC_Src(PC_Src), .ALU_Sel(ALU_Sel), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    function automatic vec_t observed();
        vec_t v;
        v = {PC_Write, MEM_ReadWrite, IR_Write, Reg_Write, AB_Write, ALUOut_Write,
             EPC_Write, ALUSrc_A, ALUSrc_B, IorD, Reg_Dst, Mem_To_Reg, PC_Src, ALU_Sel};
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exception entry: save PC-4, two-cycle vector read, jump to handler.
    task automatic push_exc();
        vec_t c;
        c = '0; c.srcb = 2'd1; c.alu = 3'b010; c.epcw = 1'b1; exp_q.push_back(c);
        c = '0; c.iord = 2'd2; exp_q.push_back(c);
        exp_q.push_back(c);
        c = '0; c.pcsrc = 3'd4; c.pcw = 1'b1; exp_q.push_back(c);
    endtask

    // Reference model: per-cycle control vectors for one instruction,
    // starting at the first fetch cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic e, input logic ov);
        vec_t c;
        exp_q.delete();
        c = '0; exp_q.push_back(c); exp_q.push_back(c);
        c = '0; c.irw = 1; c.srcb = 2'd1; c.alu = 3'b001; c.pcw = 1; exp_q.push_back(c);
        c = '0; c.abw = 1; c.srcb = 2'd3; c.alu = 3'b001; c.aow = 1; exp_q.push_back(c);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c = '0; c.srca = 1; c.aow = 1;
            c.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(c);
            if (EXC_EN && ov && fn != 6'h24) push_exc();
            else begin c = '0; c.rdst = 2'd1; c.rw = 1; exp_q.push_back(c); end
        end else if (op == 6'h00 && fn == 6'h08) begin
            c = '0; c.srca = 1; c.pcw = 1; exp_q.push_back(c);
        end else if (op == 6'h08) begin
            c = '0; c.srca = 1; c.srcb = 2'd2; c.alu = 3'b001; c.aow = 1; exp_q.push_back(c);
            if (EXC_EN && ov) push_exc();
            else begin c = '0; c.rw = 1; exp_q.push_back(c); end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.srca = 1; c.alu = 3'b111; c.pcsrc = 3'd1;
            c.pcw = (op == 6'h04) ? e : !e;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.pcsrc = 3'd2; c.pcw = 1; exp_q.push_back(c);
        end else if (op == 6'h0f) begin
            c = '0; c.m2r = 3'd6; c.rw = 1; exp_q.push_back(c);
        end else if (op == 6'h23 || op == 6'h2b) begin
            c = '0; c.srca = 1; c.srcb = 2'd2; c.alu = 3'b001; c.aow = 1; exp_q.push_back(c);
            if (op == 6'h2b) begin
                c = '0; c.iord = 2'd1; c.mrw = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.iord = 2'd1; exp_q.push_back(c); exp_q.push_back(c);
                c = '0; c.m2r = 3'd1; c.rw = 1; exp_q.push_back(c);
            end
        end else if (EXC_EN) begin
            push_exc();
        end
    endtask

    // Called near a negedge with the DUT in FETCH0; returns the same way.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic e, input logic ov, input int id);
        build(op, fn, e, ov);
        opcode = op; funct = fn; eq = e; overflow = ov;
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            check($sformatf("i%0d_op%h_fn%h_cyc%0d", id, op, fn, k + 1),
                  32'(observed()), 32'(exp_q[k]));
            @(negedge clock);
        end
        #1;
        check($sformatf("i%0d_return_fetch0", id), 32'(state_dbg), 32'(ST_FETCH0));
    endtask

    task automatic release_reset(input string tag);
        vec_t c;
        @(negedge clock);
        reset = 1'b1;
        #1;
        c = '0; c.rw = 1; c.rdst = 2'd2; c.m2r = 3'd7;
        check({tag, "_reset_state"}, 32'(state_dbg), 32'(ST_RESET));
        check({tag, "_reset_wr29"}, 32'(observed()), 32'(c));
        @(negedge clock);
        #1;
        check({tag, "_fetch0_state"}, 32'(state_dbg), 32'(ST_FETCH0));
        check({tag, "_fetch0_outs"}, 32'(observed()), 32'(0));
    endtask

    initial begin
        logic [5:0] op, fn;
        logic       e, ov;
        int         pick;

        // Reset held: RESET state, every output quiet.
        #12;
        check("rst_held_state", 32'(state_dbg), 32'(ST_RESET));
        check("rst_held_outs", 32'(observed()), 32'(0));
        @(posedge clock); #2;
        check("rst_held_clk_state", 32'(state_dbg), 32'(ST_RESET));
        check("rst_held_clk_outs", 32'(observed()), 32'(0));
        release_reset("por");

        // Directed instructions.
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 1);   // add
        run_instr(6'h00, 6'h22, 1'b0, 1'b1, 2);   // sub, overflow
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, 3);   // and, overflow ignored
        run_instr(6'h04, 6'h15, 1'b1, 1'b0, 4);   // beq taken
        run_instr(6'h04, 6'h15, 1'b0, 1'b0, 5);   // beq not taken
        run_instr(6'h05, 6'h00, 1'b1, 1'b0, 6);   // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 7);   // bne taken
        run_instr(6'h23, 6'h01, 1'b0, 1'b0, 8);   // lw
        run_instr(6'h2b, 6'h02, 1'b0, 1'b0, 9);   // sw
        run_instr(6'h08, 6'h03, 1'b0, 1'b1, 10);  // addi, overflow
        run_instr(6'h08, 6'h03, 1'b0, 1'b0, 11);  // addi
        run_instr(6'h02, 6'h3f, 1'b0, 1'b0, 12);  // j
        run_instr(6'h00, 6'h08, 1'b0, 1'b0, 13);  // jr
        run_instr(6'h0f, 6'h0a, 1'b0, 1'b0, 14);  // lui
        run_instr(6'h3f, 6'h00, 1'b0, 1'b0, 15);  // unknown opcode
        run_instr(6'h00, 6'h21, 1'b0, 1'b0, 16);  // unknown funct

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 12));
            fn = 6'($urandom);
            e  = 1'($urandom);
            ov = 1'($urandom);
            case (pick)
                0:  begin op = 6'h00; fn = 6'h20; end
                1:  begin op = 6'h00; fn = 6'h22; end
                2:  begin op = 6'h00; fn = 6'h24; end
                3:  begin op = 6'h00; fn = 6'h08; end
                4:  op = 6'h08;
                5:  op = 6'h04;
                6:  op = 6'h05;
                7:  op = 6'h02;
                8:  op = 6'h0f;
                9:  op = 6'h23;
                10: op = 6'h2b;
                11: op = 6'h11;
                default: begin op = 6'h00; fn = 6'h3f; end
            endcase
            run_instr(op, fn, e, ov, 100 + n);
        end

        // Reset asserted while in LW0 aborts the load.
        opcode = 6'h23; funct = 6'h00; eq = 1'b0; overflow = 1'b0;
        build(6'h23, 6'h00, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        #1;
        check("abort_in_lw0", 32'(observed()), 32'(exp_q[5]));
        reset = 1'b0;
        #1;
        check("abort_state", 32'(state_dbg), 32'(ST_RESET));
        check("abort_outs", 32'(observed()), 32'(0));
        @(negedge clock); #1;
        check("abort_hold_state", 32'(state_dbg), 32'(ST_RESET));
        check("abort_hold_outs", 32'(observed()), 32'(0));
        release_reset("rerun");
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
